// File: rtl/puf_challenge_sequencer.sv
// Race-PUF challenge sequencer: loads a seed challenge, then for each response bit
// settles the arbiter, runs one race and steps the challenge through an 8-bit LFSR.
//
// state  | meaning
// IDLE   | waiting for start; arbiter held in reset
// SETTLE | arb_rst held high for SETTLE cycles before a race
// RACE   | race enabled; waiting for arbiter_done or timeout
// NEXT   | one cycle between races; advance challenge/bit index or finish
// DONE   | one-cycle completion pulse
module puf_challenge_sequencer #(
    parameter int N_BITS  = 8,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] seed,
    input  logic       arbiter_done,
    output logic [7:0] challenge,
    output logic       race_en,
    output logic       arb_rst,
    output logic [3:0] bit_idx,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [7:0]    WAIT_LOAD   = 8'(TIMEOUT - 1);
    localparam logic [3:0]    LAST_BIT    = 4'(N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_RACE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t         state;
    logic [SW-1:0]  settle_cnt;
    logic [7:0]     wait_cnt;
    logic [7:0]     lfsr_next;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting left
    assign lfsr_next = {challenge[6:0], challenge[7] ^ challenge[5] ^ challenge[4] ^ challenge[3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            challenge   <= 8'h00;
            race_en     <= 1'b0;
            arb_rst     <= 1'b1;
            bit_idx     <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            settle_cnt  <= '0;
            wait_cnt    <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        challenge   <= (seed == 8'h00) ? 8'h01 : seed;
                        bit_idx     <= 4'd0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        settle_cnt  <= SETTLE_LOAD;
                        state       <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        arb_rst  <= 1'b0;
                        race_en  <= 1'b1;
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_RACE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_RACE: begin
                    // a result in the final allowed cycle still counts as success
                    if (arbiter_done) begin
                        race_en <= 1'b0;
                        arb_rst <= 1'b1;
                        state   <= S_NEXT;
                    end else if (wait_cnt == 8'h00) begin
                        race_en     <= 1'b0;
                        arb_rst     <= 1'b1;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_NEXT: begin
                    if (bit_idx == LAST_BIT) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        bit_idx    <= bit_idx + 1'b1;
                        challenge  <= lfsr_next;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: a timeline model expands each request into
// per-cycle stimulus and expected outputs, checked every cycle, plus literal pins.
module tb_puf_challenge_sequencer;

    localparam int N_BITS  = 8;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] seed;
    logic       arbiter_done;
    logic [7:0] challenge;
    logic       race_en;
    logic       arb_rst;
    logic [3:0] bit_idx;
    logic       busy;
    logic       done;
    logic       timeout_err;

    always #5 clk = ~clk;

    puf_challenge_sequencer #(
        .N_BITS (N_BITS),
        .SETTLE (SETTLE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed        (seed),
        .arbiter_done(arbiter_done),
        .challenge   (challenge),
        .race_en     (race_en),
        .arb_rst     (arb_rst),
        .bit_idx     (bit_idx),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic       st;
        logic [7:0] sd;
        logic       ad;
        logic       r;
        logic       chk;
        logic [7:0] chal;
        logic       re;
        logic       ar;
        logic [3:0] idx;
        logic       bsy;
        logic       dn;
        logic       terr;
        int         tag;
    } vec_t;

    vec_t q[$];
    vec_t cur;
    logic cur_valid = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    logic [7:0] m_chal = 8'h00;
    logic [3:0] m_idx = 4'd0;
    logic       m_err = 1'b0;

    logic [7:0] obs_chal [0:1023];
    logic [3:0] obs_idx  [0:1023];
    logic       obs_terr [0:1023];
    logic       obs_done [0:1023];
    int         obs_cyc  [0:1023];

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // expected outputs come from the model state at the time the cycle is appended
    task automatic push(input logic st, input logic [7:0] sd, input logic ad, input logic r,
                        input logic re, input logic ar, input logic bsy, input logic dn,
                        input int tag);
        vec_t v;
        v.st = st; v.sd = sd; v.ad = ad; v.r = r; v.chk = 1'b1;
        v.chal = m_chal; v.re = re; v.ar = ar; v.idx = m_idx;
        v.bsy = bsy; v.dn = dn; v.terr = m_err; v.tag = tag;
        q.push_back(v);
    endtask

    task automatic idle(input int n, input logic stray);
        for (int i = 0; i < n; i++) push(1'b0, 8'h00, stray, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    endtask

    // d0: RACE cycle of arbiter_done for bit 0, d: for later bits;
    // to_bit: bit that never resolves; rst_bit: bit whose race is cut by reset
    task automatic request(input logic [7:0] sd, input int d0, input int d, input int to_bit,
                           input int rst_bit, input logic noise, input int tb);
        push(1'b1, sd, noise, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, tb);
        m_chal = (sd == 8'h00) ? 8'h01 : sd;
        m_idx  = 4'd0;
        m_err  = 1'b0;
        for (int b = 0; b < N_BITS; b++) begin
            int dd;
            dd = (b == 0) ? d0 : d;
            for (int s = 0; s < SETTLE; s++)
                push(noise, 8'h00, noise, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, (s == 0) ? tb + 1 + b : 0);
            if (b == rst_bit) begin
                push(noise, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
                m_chal = 8'h00; m_idx = 4'd0; m_err = 1'b0;
                push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, tb + 21);
                return;
            end
            if (b == to_bit) begin
                for (int j = 1; j <= TIMEOUT; j++)
                    push(noise, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
                m_err = 1'b1;
                break;
            end
            for (int j = 1; j <= dd; j++)
                push(noise, 8'h00, (j == dd), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
            push(noise, 8'h00, noise, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
            if (b < N_BITS - 1) begin
                m_chal = lfsr_step(m_chal);
                m_idx  = m_idx + 4'd1;
            end
        end
        push(noise, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, tb + 20);
    endtask

    always @(negedge clk) begin
        if (cur_valid) begin
            if (cur.chk) begin
                check("challenge", 32'(challenge), 32'(cur.chal));
                check("race_en", 32'(race_en), 32'(cur.re));
                check("arb_rst", 32'(arb_rst), 32'(cur.ar));
                check("bit_idx", 32'(bit_idx), 32'(cur.idx));
                check("busy", 32'(busy), 32'(cur.bsy));
                check("done", 32'(done), 32'(cur.dn));
                check("timeout_err", 32'(timeout_err), 32'(cur.terr));
                check("race_arb_exclusive", 32'(race_en & arb_rst), 32'd0);
            end
            if (cur.tag != 0) begin
                obs_chal[cur.tag] = challenge;
                obs_idx[cur.tag]  = bit_idx;
                obs_terr[cur.tag] = timeout_err;
                obs_done[cur.tag] = done;
                obs_cyc[cur.tag]  = cyc;
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; seed = 8'h00; arbiter_done = 1'b0;

        for (int i = 0; i < 3; i++) push(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        q[0].chk = 1'b0;
        idle(2, 1'b1);
        request(8'hA5, 3, 3, -1, -1, 1'b0, 100);
        request(8'h00, 1, 1, -1, -1, 1'b1, 200);
        request(8'h3C, 3, 3, 0, -1, 1'b0, 300);
        idle(2, 1'b1);
        request(8'h5A, 255, 2, -1, -1, 1'b0, 400);
        request(8'h77, 2, 2, -1, 4, 1'b1, 500);
        idle(3, 1'b1);
        request(8'h77, 4, 4, -1, -1, 1'b0, 600);
        idle(2, 1'b0);

        foreach (q[i]) begin
            @(posedge clk);
            #1;
            rst          = q[i].r;
            start        = q[i].st;
            seed         = q[i].sd;
            arbiter_done = q[i].ad;
            cur          = q[i];
            cyc          = i;
            cur_valid    = 1'b1;
        end
        @(posedge clk);
        #1;
        cur_valid = 1'b0;

        check("seqA_chal0", 32'(obs_chal[101]), 32'h A5);
        check("seqA_chal1", 32'(obs_chal[102]), 32'h 4A);
        check("seqA_chal2", 32'(obs_chal[103]), 32'h 95);
        check("seqA_chal3", 32'(obs_chal[104]), 32'h 2A);
        check("seqA_done_latency", 32'(obs_cyc[120] - obs_cyc[100]), 32'd49);
        check("seqA_done_pulse", 32'(obs_done[120]), 32'd1);
        check("seqA_no_err", 32'(obs_terr[120]), 32'd0);
        check("seed0_chal0", 32'(obs_chal[201]), 32'h01);
        check("seed0_chal1", 32'(obs_chal[202]), 32'h02);
        check("timeout_latency", 32'(obs_cyc[320] - obs_cyc[300]), 32'd258);
        check("timeout_flag", 32'(obs_terr[320]), 32'd1);
        check("timeout_bit_idx", 32'(obs_idx[320]), 32'd0);
        check("timeout_done", 32'(obs_done[320]), 32'd1);
        check("err_sticky_at_start", 32'(obs_terr[400]), 32'd1);
        check("err_cleared", 32'(obs_terr[401]), 32'd0);
        check("last_cycle_done_bit1", 32'(obs_idx[402]), 32'd1);
        check("reset_chal", 32'(obs_chal[521]), 32'd0);
        check("reset_done_low", 32'(obs_done[521]), 32'd0);
        check("full_after_reset_idx", 32'(obs_idx[620]), 32'd7);
        check("full_after_reset_done", 32'(obs_done[620]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Initiator side of the race-PUF response capture path: it drives per-bit challenges to the race oscillators and arbiter, and collects nothing itself. On a start request it loads a seed challenge and runs the arbiter once per response bit. For each bit it resets the arbiter, enables the race and waits for `arbiter_done`, then advances the challenge with an 8-bit LFSR. The downstream response buffer consumes the same `arbiter_done`/`arbiter_result` stream and assembles the 8-bit response.

## Interface
- `N_BITS`, 8: races per request, i.e. response bits produced; 1..15.
- `SETTLE`, 2: cycles `arb_rst` is held high before each race; at least 1.
- `TIMEOUT`, 255: maximum RACE cycles allowed per bit before the request aborts; 1..255.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request strobe; sampled only in IDLE.
- `seed`  in  8  initial challenge; sampled with `start`.
- `arbiter_done`  in  1  arbiter has resolved the current race; honoured only in RACE.
- `challenge`  out  8  challenge applied to the delay lines.
- `race_en`  out  1  launches and holds the race.
- `arb_rst`  out  1  resets arbiter and race counters.
- `bit_idx`  out  4  index of the bit currently being raced.
- `busy`  out  1  a request is in progress.
- `done`  out  1  one-cycle completion pulse.
- `timeout_err`  out  1  last request aborted on timeout; sticky until the next accepted `start`.

## Operation
- Reset values: `challenge`=0, `race_en`=0, `arb_rst`=1, `bit_idx`=0, `busy`=0, `done`=0, `timeout_err`=0, state IDLE.
- IDLE: `arb_rst`=1, `race_en`=0, `busy`=0.
  - On `start`=1: `challenge`<=`seed`, or 8'h01 if `seed`=0 (avoids LFSR lockup).
  - Same edge: `bit_idx`<=0, `timeout_err`<=0, `busy`<=1, go SETTLE.
- SETTLE: `arb_rst`=1, `race_en`=0, for exactly `SETTLE` cycles, then go RACE.
- RACE: `arb_rst`=0, `race_en`=1. An 8-bit wait counter starts at 0 on entry and increments each RACE cycle.
  - `arbiter_done`=1: go NEXT.
  - Otherwise, when the counter reaches `TIMEOUT`-1: `timeout_err`<=1, go DONE.
  - `arbiter_done` in the final allowed cycle: done wins, no error is flagged.
- NEXT (1 cycle): `race_en`=0, `arb_rst`=1.
  - If `bit_idx`=`N_BITS`-1, go DONE; `challenge` and `bit_idx` hold.
  - Otherwise `bit_idx`<=`bit_idx`+1, `challenge`<={`challenge`[6:0], c7^c5^c4^c3}, go SETTLE.
  - The LFSR polynomial is x^8+x^6+x^5+x^4+1 and wraps naturally; `bit_idx` never exceeds `N_BITS`-1.
- DONE (1 cycle): `done`=1, `busy`=0, `arb_rst`=1, go IDLE.
  - `challenge` holds its last value and `timeout_err` holds until the next accepted `start`.
- Ignored inputs:
  - `start` outside IDLE, including in DONE.
  - `arbiter_done` outside RACE.
- `rst` asserted in any state: all outputs and state return to reset values at that edge; no `done` pulse is produced.

## Timing
- `start` is sampled at edge E. `busy`, the loaded `challenge` and `arb_rst`=1 are visible from E+1.
- Per bit: `SETTLE` + D + 1 cycles, where D (≥1) is the RACE cycle in which `arbiter_done` is high.
- `done` is high in cycle `N_BITS`·(`SETTLE`+D+1)+1 after E.
  - Defaults with D=3: cycle 49.
- `race_en` and `arb_rst` are registered and never high in the same cycle.
- `race_en` drops one cycle after `arbiter_done` is sampled.
- Back-to-back requests: the earliest next `start` is accepted in the first IDLE cycle after `done`.

## Test plan
- `seed`=8'hA5, `arbiter_done` pulsed in RACE cycle 3 for every bit:
  - `challenge` sequence A5, 4A, 95, 2A, …; `bit_idx` steps 0→7.
  - `done` pulses once, 49 cycles after `start`; `timeout_err`=0.
- `seed`=8'h00 → first `challenge`=8'h01, second 8'h02.
- `arbiter_done` never asserted, `TIMEOUT`=255:
  - After `SETTLE` then 255 RACE cycles, `timeout_err`=1 and `done` pulses with `bit_idx`=0.
  - Next `start` clears `timeout_err`.
- `arbiter_done` exactly in RACE cycle 255 → no error; sequence continues to `bit_idx`=1.
- Stray `arbiter_done` during SETTLE and IDLE, and `start` re-pulsed mid-request → no state change, no second request.
- `rst` asserted during RACE of bit 4 → next cycle all outputs at reset values, `done` never pulses.
  - A new `start` after release runs a full 8-bit sequence.
